// File: rtl/timer_pkg.sv
// Shared types and widths for the timing subsystem (down-count timer and interval meter).
package timer_pkg;

  typedef enum logic {IDLE, RUN} meter_state_t;

  localparam int TIMER_WIDTH = 10;

endpackage : timer_pkg

// File: rtl/interval_meter_if.sv
// Control/result bundle between an interval meter and its user.
interface interval_meter_if
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
);

  logic             start;
  logic             stop;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             ovf;

  modport master (output start, output stop,
                  input  busy,  input  result, input valid, input ovf);

  modport slave  (input  start, input  stop,
                  output busy,  output result, output valid, output ovf);

endinterface : interval_meter_if

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping, with synchronous clear.
module sat_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  assign at_max = &q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/interval_meter.sv
// Counts clock edges from start to stop and reports the interval with a one-cycle valid.
// Build option INTERVAL_METER_TIMEOUT_EN: a run that saturates ends by itself one edge later.
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | no measurement open; start opens one
//   RUN   | counting edges since start; stop captures result
module interval_meter
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic              clk,
  input  logic              areset_n,
  interval_meter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX = '1;

  meter_state_t     state_q, state_d;
  logic [WIDTH-1:0] cnt;
  logic             at_max;
  logic             cnt_clr, cnt_inc;
  logic             sat_q, sat_clr, sat_set;
  logic             cap_en, cap_ovf;
  logic [WIDTH-1:0] cap_val, cnt_next_sat;
  logic [WIDTH-1:0] result_q;
  logic             valid_q, ovf_q;

  sat_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .q        (cnt),
    .at_max   (at_max)
  );

  // The value a stop on this edge reports: the interval counted so far plus this edge.
  assign cnt_next_sat = at_max ? MAX : cnt + 1'b1;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    sat_clr = 1'b0;
    sat_set = 1'b0;
    cap_en  = 1'b0;
    cap_val = '0;
    cap_ovf = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.stop) begin
          cap_en = 1'b1;
        end else if (bus.start) begin
          cnt_clr = 1'b1;
          sat_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          cap_en  = 1'b1;
          cap_val = cnt_next_sat;
          cap_ovf = sat_q | at_max;
          // start on the same edge opens the next measurement with no gap
          if (bus.start) begin
            cnt_clr = 1'b1;
            sat_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.start) begin
          cnt_clr = 1'b1;
          sat_clr = 1'b1;
        end else begin
`ifdef INTERVAL_METER_TIMEOUT_EN
          if (at_max) begin
            cap_en  = 1'b1;
            cap_val = MAX;
            cap_ovf = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
`else
          cnt_inc = 1'b1;
          sat_set = at_max;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (sat_clr) begin
        sat_q <= 1'b0;
      end else if (sat_set) begin
        sat_q <= 1'b1;
      end
      valid_q <= cap_en;
      if (cap_en) begin
        result_q <= cap_val;
        ovf_q    <= cap_ovf;
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule : interval_meter

// File: doc/interval_meter.md
# interval_meter

Measures the number of clock cycles between a `start` pulse and a `stop` pulse and reports it as an unsigned count with a one-cycle `valid` strobe. It is the inverse of the loadable down-count timer: that block turns a count into a delay, and this block turns a delay into a count. A measured value loaded into the timer reproduces the same interval, since `tc` rises the same number of edges after `load`. It sits beside the timer in the timing subsystem and is used to calibrate timer reload values.

## Interface
- `WIDTH`, default 10: width of the count and result. Matches the timer's `data` width.
- `clk` input, 1 bit: the single clock. All logic is sampled on the rising edge.
- `areset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begins or restarts a measurement.
- `stop` input, 1 bit: ends the current measurement.
- `busy` output, 1 bit: high while in RUN.
- `result` output, WIDTH bits: the last captured interval.
- `valid` output, 1 bit: one-cycle pulse that marks a new `result`.
- `ovf` output, 1 bit: the captured interval saturated. Updated together with `result`.

## Operation
- The FSM has two states, IDLE and RUN. An internal counter `cnt` is WIDTH bits wide.
- **IDLE, `start`=1, `stop`=0:** `cnt`<=0, go to RUN.
- **IDLE, `start`=1, `stop`=1:** capture `result`=0 and `ovf`=0, pulse `valid`, stay in IDLE.
- **IDLE, `stop` only:** ignored. No `valid` pulse.
- **RUN, neither input:** `cnt`<=sat(`cnt`+1). When `cnt` is already 2^WIDTH−1 it holds there and an internal `sat` flag is set.
- **RUN, `stop`=1, `start`=0:** capture `result`<=sat(`cnt`+1) and `ovf`<=`sat` OR (`cnt`==max). Pulse `valid`, go to IDLE.
- **RUN, `stop`=1 and `start`=1 together:** capture as for `stop`, then `cnt`<=0 and stay in RUN. Back-to-back measurements lose no cycle.
- **RUN, `start` only:** restart. `cnt`<=0 and `sat` is cleared. No `valid` pulse, and `result` is unchanged.
- Interval definition: with `start` sampled at edge t0 and `stop` sampled at edge t1, `result` = t1−t0, saturated at 2^WIDTH−1.
- Arithmetic is unsigned. Increments saturate and never wrap.

## Timing
- Reset values: state IDLE, `cnt`=0, `sat`=0, `busy`=0, `result`=0, `valid`=0, `ovf`=0.
- Asserting `areset_n` low in the middle of a measurement aborts it. No `valid` pulse is produced.
- All outputs are registered.
- `busy` rises in the cycle after the `start` edge and falls in the cycle after the capturing edge. In the restart-with-capture case it stays high.
- `valid`, `result` and `ovf` update together in the cycle after the `stop` edge.
- `valid` is high for exactly one cycle per capture.
- `result` and `ovf` hold until the next capture.
- The minimum measurable interval is 1: `stop` one edge after `start`. The simultaneous-in-IDLE case reports 0.

## Configuration
- **`INTERVAL_METER_TIMEOUT_EN` defined:** a RUN that reaches `cnt`=2^WIDTH−1 ends automatically on the next edge. That edge captures `result`=2^WIDTH−1 with `ovf`=1, pulses `valid` and returns to IDLE. A later `stop` is then ignored.
- **Undefined:** the counter stays saturated in RUN until `stop` or `start` arrives, and the capture reports max with `ovf`=1.

## Structure
- Package `timer_pkg` holds:
  - `typedef enum logic {IDLE, RUN} meter_state_t`
  - `localparam int TIMER_WIDTH = 10`, which is the default for `WIDTH` here and for the timer.
- Sub-module `sat_counter`, parameterized by WIDTH. Inputs: `clr` and `inc`. Outputs: `q` and `at_max`. It performs the saturating increment and the synchronous clear.
- The FSM, capture registers and timeout option live in `interval_meter`.

## Test plan
- Reset, then `start` at edge 2 and `stop` at edge 5 → one `valid` pulse with `result`=3, `ovf`=0, and `busy` high for 3 cycles.
- `start` at edge t, `stop` at t+1 → `result`=1. In IDLE, `start` and `stop` together → `result`=0 with a `valid` pulse.
- `start`, then `start` again after 4 cycles, then `stop` 6 cycles later → a single `valid` with `result`=6.
- `start`, then `start`+`stop` together at +7, then `stop` at +2 after that → two `valid` pulses reporting 7 and then 2, with `busy` never dropping in between.
- `start`, then `stop` 1100 cycles later with WIDTH=10:
  - Macro undefined → `result`=1023, `ovf`=1 at the stop edge.
  - Macro defined → `valid` with `result`=1023 and `ovf`=1 at edge start+1024, and the late `stop` produces no pulse.
- `areset_n` asserted low 3 cycles into a run → all outputs 0 immediately. A following `stop` with no new `start` produces no `valid`.
